// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the uart_tx_dev peripheral.
// Holds the register offsets decoded from Addr[3:2], the STATUS bit layout,
// the transmitter FSM encoding and the bit-period helper.
package uart_tx_dev_pkg;

    // Register offsets (word index within the device window)
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

    // Transmitter FSM encoding
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A divisor of zero would give a zero-length bit; clamp to one clock.
    function automatic logic [15:0] bit_period(input logic [15:0] divisor);
        logic [15:0] period;
        if (divisor == 16'd0) begin
            period = 16'd1;
        end else begin
            period = divisor;
        end
        return period;
    endfunction

endpackage

// File: rtl/uart_tx_dev_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (contents lost)
//   push, din         - write request and data; dropped when full
//   pop, dout         - read request and head-of-queue data (show-ahead)
//   full, empty       - occupancy flags
//   count             - number of stored entries, 0..DEPTH
//   overflow          - one-cycle pulse when a push is dropped because full
// A push while full is dropped even if a pop happens in the same cycle.
module uart_tx_dev_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign overflow  = push && full;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped UART transmitter (8N1, LSB first).
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   Addr[31:2]  - word address; only Addr[3:2] selects a register
//   WE, Din     - write strobe (already device-qualified) and write data
//   Dout        - combinational read data for the selected register
//   IRQ         - registered level interrupt: irq_en && FIFO empty && idle
//   tx          - registered serial line, idles high
// Registers: 0 DATA (push), 1 STATUS, 2 CTRL {irq_en,en}, 3 DIVISOR[15:0].
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Register file
    logic        en_r;
    logic        irq_en_r;
    logic [15:0] divisor_r;
    logic        overflow_r;

    // Transmitter datapath
    tx_state_e   state_r, state_n;
    logic [7:0]  shift_r, shift_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic [15:0] baud_r, baud_n;
    logic        tx_r, tx_n;
    logic        irq_r;

    // FIFO interface
    logic          push_s;
    logic          pop_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_ovf_s;

    logic [15:0]   reload_s;
    logic          bit_done_s;
    logic [1:0]    reg_sel_s;
    logic          unused_s;

    assign reg_sel_s  = Addr[3:2];
    assign push_s     = WE && (reg_sel_s == REG_DATA);
    assign reload_s   = bit_period(divisor_r) - 16'd1;
    assign bit_done_s = (baud_r == 16'd0);
    assign tx         = tx_r;
    assign IRQ        = irq_r;
    assign unused_s   = ^{Addr[31:4], Din[31:16]};

    uart_tx_dev_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .din      (Din[7:0]),
        .pop      (pop_s),
        .dout     (fifo_dout_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s),
        .overflow (fifo_ovf_s)
    );

    // Software-visible registers; overflow is sticky until any STATUS write
    always_ff @(posedge clk) begin
        if (reset) begin
            en_r       <= 1'b0;
            irq_en_r   <= 1'b0;
            divisor_r  <= 16'(DIV_RESET);
            overflow_r <= 1'b0;
        end else begin
            if (WE) begin
                case (reg_sel_s)
                    REG_CTRL: begin
                        en_r     <= Din[0];
                        irq_en_r <= Din[1];
                    end
                    REG_DIVISOR: divisor_r <= Din[15:0];
                    default: ;
                endcase
            end
            if (WE && (reg_sel_s == REG_STATUS)) begin
                overflow_r <= 1'b0;
            end else if (fifo_ovf_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmitter state, datapath and interrupt registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= TX_IDLE;
            shift_r   <= 8'd0;
            bit_cnt_r <= 3'd0;
            baud_r    <= 16'd0;
            tx_r      <= 1'b1;
            irq_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            shift_r   <= shift_n;
            bit_cnt_r <= bit_cnt_n;
            baud_r    <= baud_n;
            tx_r      <= tx_n;
            irq_r     <= irq_en_r && fifo_empty_s && (state_r == TX_IDLE);
        end
    end

    // Next-state logic; the baud counter is reloaded from the current divisor
    // at every bit boundary so a DIVISOR write never stretches a bit in flight
    always_comb begin
        state_n   = state_r;
        shift_n   = shift_r;
        bit_cnt_n = bit_cnt_r;
        baud_n    = baud_r;
        tx_n      = tx_r;
        pop_s     = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (en_r && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_n = fifo_dout_s;
                    baud_n  = reload_s;
                    tx_n    = 1'b0;
                    state_n = TX_START;
                end else begin
                    tx_n    = 1'b1;
                end
            end
            TX_START: begin
                if (bit_done_s) begin
                    baud_n    = reload_s;
                    bit_cnt_n = 3'd0;
                    tx_n      = shift_r[0];
                    state_n   = TX_DATA;
                end else begin
                    baud_n    = baud_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_done_s) begin
                    baud_n    = reload_s;
                    shift_n   = shift_r >> 1;
                    bit_cnt_n = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = TX_STOP;
                    end else begin
                        tx_n    = shift_r[1];
                    end
                end else begin
                    baud_n    = baud_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_done_s) begin
                    if (en_r && !fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_n = fifo_dout_s;
                        baud_n  = reload_s;
                        tx_n    = 1'b0;
                        state_n = TX_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = TX_IDLE;
                    end
                end else begin
                    baud_n  = baud_r - 16'd1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = TX_IDLE;
            end
        endcase
    end

    // Read mux
    always_comb begin
        Dout = 32'd0;
        case (reg_sel_s)
            REG_DATA: Dout = 32'd0;
            REG_STATUS: begin
                Dout[STAT_BUSY]  = (state_r != TX_IDLE);
                Dout[STAT_FULL]  = fifo_full_s;
                Dout[STAT_EMPTY] = fifo_empty_s;
                Dout[STAT_OVF]   = overflow_r;
                Dout[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count_s);
            end
            REG_CTRL:    Dout = {30'd0, irq_en_r, en_r};
            REG_DIVISOR: Dout = {16'd0, divisor_r};
            default:     Dout = 32'd0;
        endcase
    end

endmodule
